// File: rtl/sensor_pkg.sv
// Shared types and defaults for the sensor frame sequencer.
// Feature macro SENSOR_FRAME_CTRL_CONTINUOUS_EN (see sensor_frame_ctrl.sv) is
// not referenced here.
package sensor_pkg;

    // Frame phases, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    localparam int DEF_PIXEL_ARRAY_HEIGHT = 2;
    localparam int DEF_C_ERASE            = 5;
    localparam int DEF_C_CONVERT          = 256;
    localparam int DEF_C_READ_ROW         = 5;

    // Phase timer width: must hold C_CONVERT-1 (<=255) and expose_q-1.
    localparam int TIMER_W = 8;

    // An exposure request of zero still gets one exposure cycle.
    function automatic logic [7:0] clamp_expose(input logic [7:0] t);
        logic [7:0] v;
        if (t == 8'd0) begin
            v = 8'd1;
        end else begin
            v = t;
        end
        return v;
    endfunction

endpackage

// File: rtl/sensor_frame_ctrl_phase_timer.sv
// Loadable down-counter shared by every frame phase and every row window.
// Loading N gives N+1 cycles until done; done holds while the count sits at 0.
module phase_timer
    import sensor_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Reload on phase/window entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == '0);

endmodule

// File: rtl/sensor_frame_ctrl.sv
// Frame sequencer for the pixel array: ERASE -> EXPOSE -> CONVERT -> READ.
// Optional macro SENSOR_FRAME_CTRL_CONTINUOUS_EN: when defined, READ loops back
// to ERASE (free-running) and frame_done marks the first ERASE cycle of the
// following frame; otherwise each start runs exactly one frame.
// Every output is a flop loaded from the next-state decode, so outputs change
// on the same edge as the state they describe.
module sensor_frame_ctrl
    import sensor_pkg::*;
#(
    parameter int PIXEL_ARRAY_HEIGHT = DEF_PIXEL_ARRAY_HEIGHT,
    parameter int C_ERASE            = DEF_C_ERASE,
    parameter int C_CONVERT          = DEF_C_CONVERT,
    parameter int C_READ_ROW         = DEF_C_READ_ROW,
    localparam int ROW_IDX_W         = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [7:0]                    expose_time,
    output logic                          erase,
    output logic                          expose,
    output logic                          convert,
    output logic [7:0]                    pixel_counter,
    output logic [PIXEL_ARRAY_HEIGHT-1:0] read,
    output logic                          row_valid,
    output logic [ROW_IDX_W-1:0]          row_index,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int H = PIXEL_ARRAY_HEIGHT;

    localparam logic [TIMER_W-1:0]   LP_ERASE_LOAD   = TIMER_W'(C_ERASE - 1);
    localparam logic [TIMER_W-1:0]   LP_CONVERT_LOAD = TIMER_W'(C_CONVERT - 1);
    localparam logic [TIMER_W-1:0]   LP_ROW_LOAD     = TIMER_W'(C_READ_ROW - 1);
    localparam logic [ROW_IDX_W-1:0] LP_LAST_ROW     = ROW_IDX_W'(H - 1);
    localparam logic [H-1:0]         LP_READ_FIRST   = H'(1'b1);

    state_t               r_state;
    state_t               w_next_state;
    logic [7:0]           r_expose_q;

    logic                 w_load;
    logic [TIMER_W-1:0]   w_load_val;
    logic [TIMER_W-1:0]   w_count;
    logic                 w_done;
    logic                 w_latch_expose;
    logic                 w_last_row;

    // Output registers and their next values.
    logic                 r_erase,      w_erase_n;
    logic                 r_expose,     w_expose_n;
    logic                 r_convert,    w_convert_n;
    logic [7:0]           r_pix,        w_pix_n;
    logic [H-1:0]         r_read,       w_read_n;
    logic [ROW_IDX_W-1:0] r_row,        w_row_n;
    logic                 r_row_valid,  w_row_valid_n;
    logic [ROW_IDX_W-1:0] r_row_index,  w_row_index_n;
    logic                 r_busy,       w_busy_n;
    logic                 r_frame_done, w_frame_done_n;

    phase_timer #(
        .W (TIMER_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_done     (w_done)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, phase-timer reloads and exposure latch strobe.
    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_load_val     = '0;
        w_latch_expose = 1'b0;
        w_frame_done_n = 1'b0;
        w_last_row     = (r_row == LP_LAST_ROW);
        if (abort) begin
            // Abort beats everything, including a simultaneous start in IDLE.
            w_next_state = ST_IDLE;
            w_load       = 1'b1;
            w_load_val   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next_state   = ST_ERASE;
                        w_load         = 1'b1;
                        w_load_val     = LP_ERASE_LOAD;
                        w_latch_expose = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_ERASE: begin
                    if (w_done) begin
                        w_next_state = ST_EXPOSE;
                        w_load       = 1'b1;
                        w_load_val   = r_expose_q - 8'd1;
                    end else begin
                        w_next_state = ST_ERASE;
                    end
                end
                ST_EXPOSE: begin
                    if (w_done) begin
                        w_next_state = ST_CONVERT;
                        w_load       = 1'b1;
                        w_load_val   = LP_CONVERT_LOAD;
                    end else begin
                        w_next_state = ST_EXPOSE;
                    end
                end
                ST_CONVERT: begin
                    if (w_done) begin
                        w_next_state = ST_READ;
                        w_load       = 1'b1;
                        w_load_val   = LP_ROW_LOAD;
                    end else begin
                        w_next_state = ST_CONVERT;
                    end
                end
                ST_READ: begin
                    if (w_done && w_last_row) begin
                        w_frame_done_n = 1'b1;
`ifdef SENSOR_FRAME_CTRL_CONTINUOUS_EN
                        w_next_state   = ST_ERASE;
                        w_load         = 1'b1;
                        w_load_val     = LP_ERASE_LOAD;
                        w_latch_expose = 1'b1;
`else
                        w_next_state   = ST_IDLE;
                        w_load         = 1'b1;
                        w_load_val     = '0;
`endif
                    end else if (w_done) begin
                        // Next row window.
                        w_next_state = ST_READ;
                        w_load       = 1'b1;
                        w_load_val   = LP_ROW_LOAD;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_load       = 1'b1;
                    w_load_val   = '0;
                end
            endcase
        end
    end

    // Next values of the array controls, derived from the state being entered.
    always_comb begin
        w_erase_n     = (w_next_state == ST_ERASE);
        w_expose_n    = (w_next_state == ST_EXPOSE);
        w_convert_n   = (w_next_state == ST_CONVERT);
        w_busy_n      = (w_next_state != ST_IDLE);
        w_pix_n       = 8'd0;
        w_read_n      = '0;
        w_row_n       = '0;
        w_row_valid_n = 1'b0;
        w_row_index_n = '0;

        // Ramp code: restart at 0 on CONVERT entry, step by one each cycle.
        if (w_next_state == ST_CONVERT) begin
            if (r_state == ST_CONVERT) begin
                w_pix_n = r_pix + 8'd1;
            end else begin
                w_pix_n = 8'd0;
            end
        end else begin
            w_pix_n = 8'd0;
        end

        // Row select shifts one place at each window boundary. The window's
        // last cycle is the one where the timer will read zero, i.e. when it
        // reads one now and is not being reloaded.
        if (w_next_state == ST_READ) begin
            if (r_state == ST_READ) begin
                if (w_done) begin
                    w_read_n = r_read << 1'b1;
                    w_row_n  = r_row + ROW_IDX_W'(1'b1);
                end else begin
                    w_read_n = r_read;
                    w_row_n  = r_row;
                end
                w_row_valid_n = !w_done && (w_count == 8'd1);
            end else begin
                w_read_n      = LP_READ_FIRST;
                w_row_n       = '0;
                w_row_valid_n = 1'b0;
            end
        end else begin
            w_read_n      = '0;
            w_row_n       = '0;
            w_row_valid_n = 1'b0;
        end

        if (w_row_valid_n) begin
            w_row_index_n = w_row_n;
        end else begin
            w_row_index_n = '0;
        end
    end

    // Exposure length captured when a frame begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expose_q <= 8'd0;
        end else if (w_latch_expose) begin
            r_expose_q <= clamp_expose(expose_time);
        end else begin
            r_expose_q <= r_expose_q;
        end
    end

    // Output register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_erase      <= 1'b0;
            r_expose     <= 1'b0;
            r_convert    <= 1'b0;
            r_pix        <= 8'd0;
            r_read       <= '0;
            r_row        <= '0;
            r_row_valid  <= 1'b0;
            r_row_index  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_erase      <= w_erase_n;
            r_expose     <= w_expose_n;
            r_convert    <= w_convert_n;
            r_pix        <= w_pix_n;
            r_read       <= w_read_n;
            r_row        <= w_row_n;
            r_row_valid  <= w_row_valid_n;
            r_row_index  <= w_row_index_n;
            r_busy       <= w_busy_n;
            r_frame_done <= w_frame_done_n;
        end
    end

    assign erase         = r_erase;
    assign expose        = r_expose;
    assign convert       = r_convert;
    assign pixel_counter = r_pix;
    assign read          = r_read;
    assign row_valid     = r_row_valid;
    assign row_index     = r_row_index;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_sensor_frame_ctrl.sv
// Scoreboard bench for sensor_frame_ctrl (H=2, default timings).
// Stimulus pushes expected row_valid / frame_done events; a negedge monitor
// pops and compares them against a frame-relative cycle count.
module tb_sensor_frame_ctrl;

    localparam int EV_ROW  = 1;
    localparam int EV_DONE = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] expose_time;
    logic       erase;
    logic       expose;
    logic       convert;
    logic [7:0] pixel_counter;
    logic [1:0] read;
    logic       row_valid;
    logic [0:0] row_index;
    logic       busy;
    logic       frame_done;

    typedef struct {
        int         kind;
        int         fc;
        int         row;
        logic [1:0] rd;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_done   = 0;

    sensor_frame_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .expose_time   (expose_time),
        .erase         (erase),
        .expose        (expose),
        .convert       (convert),
        .pixel_counter (pixel_counter),
        .read          (read),
        .row_valid     (row_valid),
        .row_index     (row_index),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Hand-derived event times: rows end at base+4 and base+9, done at base+10.
    task automatic push_frame(input int et);
        int  eq;
        int  base;
        ev_t ev;
        eq   = (et == 0) ? 1 : et;
        base = 5 + eq + 256;
        ev.kind = EV_ROW;  ev.fc = base + 4;  ev.row = 0; ev.rd = 2'b01; exp_q.push_back(ev);
        ev.kind = EV_ROW;  ev.fc = base + 9;  ev.row = 1; ev.rd = 2'b10; exp_q.push_back(ev);
        ev.kind = EV_DONE; ev.fc = base + 10; ev.row = 0; ev.rd = 2'b00; exp_q.push_back(ev);
    endtask

    // Expected {busy,erase,expose,convert,pixel_counter,read} in frame cycle c.
    function automatic logic [13:0] exp_vec(input int c, input int eq);
        int         base;
        logic [7:0] p;
        logic [1:0] r;
        base = 5 + eq + 256;
        p    = 8'd0;
        r    = 2'b00;
        if (c < 5) begin
            return {1'b1, 1'b1, 1'b0, 1'b0, p, r};
        end else if (c < 5 + eq) begin
            return {1'b1, 1'b0, 1'b1, 1'b0, p, r};
        end else if (c < base) begin
            p = 8'(c - 5 - eq);
            return {1'b1, 1'b0, 1'b0, 1'b1, p, r};
        end else if (c < base + 10) begin
            r = ((c - base) < 5) ? 2'b01 : 2'b10;
            return {1'b1, 1'b0, 1'b0, 1'b0, p, r};
        end else begin
            return 14'd0;
        end
    endfunction

    function automatic logic [16:0] all_outs();
        return {busy, erase, expose, convert, pixel_counter, read, row_valid, row_index, frame_done};
    endfunction

    // Monitor: frame-relative cycle count restarts on each ERASE rising edge.
    int         m_fc = 0;
    int         m_run;
    logic       m_prev_erase = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            m_fc         = 0;
            m_prev_erase = 1'b0;
        end else begin
            m_run = m_fc + 1;
            if (row_valid || frame_done) begin
                ev_t e;
                int  ak;
                ak = frame_done ? EV_DONE : EV_ROW;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event: got kind=%0d fc=%0d row=%0d read=%b expected no event",
                             ak, m_run, row_index, read);
                end else begin
                    e = exp_q.pop_front();
                    if (ak == e.kind && m_run == e.fc && int'(row_index) == e.row && read == e.rd) begin
                        n_pass++;
                    end else begin
                        $display("FAIL event: got kind=%0d fc=%0d row=%0d read=%b expected kind=%0d fc=%0d row=%0d read=%b",
                                 ak, m_run, row_index, read, e.kind, e.fc, e.row, e.rd);
                    end
                end
            end
            if (frame_done) n_done++;
            if (erase && !m_prev_erase) m_fc = 0;
            else m_fc = m_run;
            m_prev_erase = erase;
        end
    end

    // Issue a one-cycle start; call at a negedge.
    task automatic pulse_start(input logic [7:0] et);
        start       = 1'b1;
        expose_time = et;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    // Full-frame waveform comparison against the cycle model.
    task automatic run_wave(input string name, input logic [7:0] et);
        int          eq;
        int          base;
        int          errs;
        int          ex_cnt;
        logic [13:0] a;
        logic [13:0] e;
        eq     = (et == 8'd0) ? 1 : int'(et);
        base   = 5 + eq + 256;
        errs   = 0;
        ex_cnt = 0;
        push_frame(int'(et));
        pulse_start(et);
        for (int c = 0; c <= base + 10; c++) begin
            @(negedge clk);
            a = {busy, erase, expose, convert, pixel_counter, read};
            e = exp_vec(c, eq);
            if (a !== e) begin
                if (errs == 0) $display("%s first divergence at cycle %0d: got %h want %h", name, c, a, e);
                errs++;
            end
            if (expose) ex_cnt++;
        end
        #1;
        check({name, "_wave_bad_cycles"}, errs, 0);
        check({name, "_expose_cycles"}, ex_cnt, eq);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int seen;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        expose_time = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", all_outs(), 0);

        // Reset asserted mid-EXPOSE: outputs clear within the same cycle.
        d0 = n_done;
        pulse_start(8'd10);
        repeat (8) @(negedge clk);
        check("pre_reset_expose", expose, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_no_done", n_done - d0, 0);
        check("reset_idle", busy, 0);

        // start together with abort in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", {busy, erase}, 0);

        // Abort on convert cycle 100.
        d0 = n_done;
        pulse_start(8'd10);
        for (int c = 0; c <= 115; c++) @(negedge clk);
        check("convert_k100", pixel_counter, 100);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_outputs", all_outs(), 0);
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (read != 2'b00 || busy) seen++;
        end
        check("abort_no_read", seen, 0);
        check("abort_no_done", n_done - d0, 0);

`ifdef SENSOR_FRAME_CTRL_CONTINUOUS_EN
        // Three free-running frames; expose_time re-latched at each new ERASE.
        d0 = n_done;
        push_frame(10);
        push_frame(20);
        push_frame(20);
        pulse_start(8'd10);
        expose_time = 8'd20;
        drain("cont", 1200);
        check("cont_erase_follows", {erase, busy}, 3);
        check("cont_done_count", n_done - d0, 3);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("cont_abort_outputs", all_outs(), 0);
`else
        // Nominal frame, exposure 10: frame_done at cycle 281.
        run_wave("e10", 8'd10);
        // Zero exposure treated as one: frame length 272.
        run_wave("e0", 8'd0);
        // Exposure 37 as a third pattern.
        run_wave("e37", 8'd37);

        // start pulses while busy are ignored and not queued.
        d0 = n_done;
        push_frame(10);
        pulse_start(8'd10);
        for (int c = 0; c <= 290; c++) begin
            @(negedge clk);
            start       = (c == 3 || c == 50 || c == 200 || c == 278);
            expose_time = 8'd50;
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("busy_start_queue", exp_q.size(), 0);
        check("busy_start_one_done", n_done - d0, 1);
        check("busy_start_idle", busy, 0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
